mix_columns_ctrl: RTL and testbench

MIX_COLUMNS_CTRL -- requirements
Module: mix_columns_ctrl

---
 rtl/aes_pkg.sv | 15 +
 rtl/mix_columns_ctrl_if.sv | 23 ++
 rtl/mix_columns_ctrl_col.sv | 32 +++
 rtl/mix_columns_ctrl.sv | 104 ++++++++++
 tb/tb_mix_columns_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES typedefs, column count and controller state enum
package aes_pkg;

  localparam int NUM_COLS = 4;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/mix_columns_ctrl_if.sv
// rtl/mix_columns_ctrl_if.sv - input/output handshake bundle for the MixColumns controller
interface mix_columns_ctrl_if;

  logic            in_valid;
  logic            in_ready;
  aes_pkg::state_t in_state;
  logic            in_skip;
  logic            out_valid;
  logic            out_ready;
  aes_pkg::state_t out_state;
  logic            busy;

  modport master (
    output in_valid, in_state, in_skip, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_skip, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/mix_columns_ctrl_col.sv
// rtl/mix_columns_ctrl_col.sv - combinational single-column AES mixColumns
module mix_columns_col
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*a is folded as xtime(a) ^ a
  assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_ctrl.sv
// rtl/mix_columns_ctrl.sv - time-shares one column unit across the four AES state columns
module mix_columns_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mix_columns_ctrl_if.slave  bus
);

  fsm_t       state, state_next;
  logic [1:0] cnt;
  state_t     work;
  state_t     result;
  col_t       col_sel;
  col_t       col_mixed;

  mix_columns_col u_col (
    .col_in  (col_sel),
    .col_out (col_mixed)
  );

  always_comb begin
    col_sel = work[127:96];
    case (cnt)
      2'd1:    col_sel = work[95:64];
      2'd2:    col_sel = work[63:32];
      2'd3:    col_sel = work[31:0];
      default: col_sel = work[127:96];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          state_next = bus.in_skip ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == 2'(NUM_COLS - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Result columns are overwritten in place; the work copy stays intact for the whole run
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      work   <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work <= bus.in_state;
            cnt  <= 2'd0;
            if (bus.in_skip) begin
              result <= bus.in_state;
            end
          end
        end
        ST_RUN: begin
          case (cnt)
            2'd0:    result[127:96] <= col_mixed;
            2'd1:    result[95:64]  <= col_mixed;
            2'd2:    result[63:32]  <= col_mixed;
            default: result[31:0]   <= col_mixed;
          endcase
          cnt <= cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_state = result;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// tb/tb_mix_columns_ctrl.sv - self-checking bench for mix_columns_ctrl
module tb_mix_columns_ctrl;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mix_columns_ctrl_if bus ();

  mix_columns_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string    name;
    state_t   st;
    bit       skip;
    state_t   exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix [2 3 1 1] applied to each column, byte 0 at the column MSB
  function automatic state_t ref_mix(input state_t s, input bit skip);
    logic [7:0] base [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    state_t     r = '0;
    base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
    if (skip) return s;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - row + 4) % 4], a[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one state, checks latency and result, then retires it with out_ready=1
  task automatic do_xfer(input string name, input state_t st, input bit skip, input state_t exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    check({name, " in_ready before offer"}, 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_state = st;
    bus.in_skip  = skip;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    n = 0;
    while (!bus.out_valid && n < 12) begin tick(); n++; end
    check({name, " edges accept->out_valid"}, 128'(n), skip ? 128'd0 : 128'd4);
    check({name, " out_state"}, bus.out_state, exp);
    tick();
    check({name, " retired"}, {126'd0, bus.out_valid, bus.in_ready}, 128'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    state_t     d;
    state_t     exp_bp;
    state_t     got[$];
    int         acc_cyc[$];
    int         n;
    int         idx;
    int         cyc;
    bit         acc, del;
    state_t     b2b[3];
    state_t     fips, single;

    fips   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    single = 128'hdb135345f20a225c01010101c6c6c6c6;

    tbl.push_back('{"fips_round1", fips, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c});
    tbl.push_back('{"single_cols", single, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6});
    tbl.push_back('{"skip_fips", fips, 1'b1, fips});
    tbl.push_back('{"all_zero", '0, 1'b0, '0});
    tbl.push_back('{"all_ff", {128{1'b1}}, 1'b0, {128{1'b1}}});

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_skip   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("reset flags {busy,out_valid,in_ready}",
          {125'd0, bus.busy, bus.out_valid, bus.in_ready}, 128'b001);
    check("reset out_state", bus.out_state, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      do_xfer(tbl[i].name, tbl[i].st, tbl[i].skip, tbl[i].exp);
    end

    for (int i = 0; i < 12; i++) begin
      bit sk;
      d  = {$urandom, $urandom, $urandom, $urandom};
      sk = ($urandom_range(3) == 0);
      do_xfer($sformatf("random%0d", i), d, sk, ref_mix(d, sk));
    end

    // Backpressure: result must hold while new offers are ignored
    bus.in_valid  = 1'b1;
    bus.in_state  = single;
    bus.in_skip   = 1'b0;
    bus.out_ready = 1'b0;
    exp_bp = ref_mix(single, 1'b0);
    tick();
    n = 0;
    while (!bus.out_valid && n < 12) begin
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    check("bp edges accept->out_valid", 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check($sformatf("bp hold out_state c%0d", i), bus.out_state, exp_bp);
      check($sformatf("bp flags {in_ready,out_valid} c%0d", i),
            {126'd0, bus.in_ready, bus.out_valid}, 128'b01);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid || bus.busy) n++;
      tick();
    end
    check("bp single delivery, no accept on retire", 128'(n), 128'd0);

    // Reset while cnt=2: accept edge, then two RUN edges
    bus.in_valid  = 1'b1;
    bus.in_state  = fips;
    bus.in_skip   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid-run still busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("after mid-run reset {busy,out_valid,in_ready}",
          {125'd0, bus.busy, bus.out_valid, bus.in_ready}, 128'b001);
    check("after mid-run reset out_state", bus.out_state, '0);
    do_xfer("post_reset_single", single, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);

    // Back-to-back with both handshakes held high
    for (int i = 0; i < 3; i++) b2b[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0;
    cyc = 0;
    bus.in_valid  = 1'b1;
    bus.in_state  = b2b[0];
    bus.in_skip   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      acc = bus.in_valid && bus.in_ready;
      del = bus.out_valid && bus.out_ready;
      if (del) got.push_back(bus.out_state);
      tick();
      cyc++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) bus.in_state = b2b[idx];
        else bus.in_valid = 1'b0;
      end
    end
    check("b2b accepts", 128'(acc_cyc.size()), 128'd3);
    check("b2b results", 128'(got.size()), 128'd3);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check($sformatf("b2b spacing %0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd6);
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      check($sformatf("b2b result %0d", i), got[i], ref_mix(b2b[i], 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
